// File: rtl/return_addr_stack_pkg.sv
// return_addr_stack_pkg: shared constants and operation decode for the VeryRISC return-address stack
package return_addr_stack_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int RAS_DEPTH  = 4;
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } ras_op_t;
  // Encoding is {push, pop}, so the decode is a straight cast.
  function automatic ras_op_t decode_op(input logic push, input logic pop);
    return ras_op_t'({push, pop});
  endfunction
endpackage

// File: rtl/return_addr_stack_mem.sv
// return_addr_stack_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port
module return_addr_stack_mem #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // Storage is never reset; validity is tracked by the stack's count.
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: LIFO of return addresses feeding the PC load port; define RSTACK_WRAP_EN to overwrite the oldest entry on a push while full
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         top_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef RSTACK_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  logic [AW-1:0] wp_q, wp_d, top_idx, waddr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, unf_q, ovf_set, unf_set, we, full_w, empty_w;
  logic [WIDTH-1:0] rdata;
  ras_op_t       op;
  assign full_w  = cnt_q == FULL_CNT;
  assign empty_w = cnt_q == '0;
  assign top_idx = wp_q - 1'b1;
  return_addr_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (we && !rst),
    .waddr_i (waddr),
    .wdata_i (push_data),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );
  // Next pointer, count, write request and error events for this cycle's operation.
  always_comb begin
    op      = decode_op(push, pop);
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = wp_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        we      = !full_w || WRAP;
        ovf_set = full_w;
        wp_d    = we ? wp_q + 1'b1 : wp_q;
        cnt_d   = full_w ? cnt_q : cnt_q + 1'b1;
      end
      OP_POP: begin
        unf_set = empty_w;
        wp_d    = empty_w ? wp_q : wp_q - 1'b1;
        cnt_d   = empty_w ? cnt_q : cnt_q - 1'b1;
      end
      OP_REPLACE: begin
        we      = 1'b1;
        unf_set = empty_w;
        waddr   = empty_w ? wp_q : top_idx;
        wp_d    = empty_w ? wp_q + 1'b1 : wp_q;
        cnt_d   = empty_w ? cnt_q + 1'b1 : cnt_q;
      end
      default: ;
    endcase
  end
  // State update; a new error in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk)
    if (rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= (ovf_q && !err_clr) || ovf_set;
      unf_q <= (unf_q && !err_clr) || unf_set;
    end
  assign top_data  = empty_w ? '0 : rdata;
  assign empty     = empty_w;
  assign full      = full_w;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: scoreboard bench comparing the stack against a queue-based reference model
module tb_return_addr_stack;
  localparam int W = 5;
  localparam int D = 4;
  typedef struct {
    int top;
    int emp;
    int ful;
    int cnt;
    int ovf;
    int unf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic err_clr = 1'b0;
  logic [W-1:0] push_data = '0;
  logic [W-1:0] top_data;
  logic empty, full, overflow, underflow;
  logic [$clog2(D):0] count;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int stk[$];
  bit m_ovf = 0;
  bit m_unf = 0;
  bit done = 0;
  always #5 clk = ~clk;
  return_addr_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .err_clr   (err_clr),
    .top_data  (top_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );
  task automatic cmp(input string n, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp_v);
    end
  endtask
  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("top_data", int'(top_data), e.top);
      cmp("empty", int'(empty), e.emp);
      cmp("full", int'(full), e.ful);
      cmp("count", int'(count), e.cnt);
      cmp("overflow", int'(overflow), e.ovf);
      cmp("underflow", int'(underflow), e.unf);
    end
  end
  task automatic step(input bit r, input bit pu, input bit po, input int d, input bit clr, input bit chk = 1);
    exp_t e;
    bit no, nu;
    @(posedge clk);
    #1;
    rst = r;
    push = pu;
    pop = po;
    push_data = W'(d);
    err_clr = clr;
    e.top = stk.size() ? stk[stk.size()-1] : 0;
    e.emp = stk.size() == 0;
    e.ful = stk.size() == D;
    e.cnt = stk.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    if (chk) sb.push_back(e);
    no = 0;
    nu = 0;
    if (r) begin
      stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (pu && po) begin
        if (stk.size() == 0) begin
          nu = 1;
          stk.push_back(d % 32);
        end else stk[stk.size()-1] = d % 32;
      end else if (pu) begin
        if (stk.size() < D) stk.push_back(d % 32);
        else begin
          no = 1;
`ifdef RSTACK_WRAP_EN
          stk.push_back(d % 32);
          void'(stk.pop_front());
`endif
        end
      end else if (po) begin
        if (stk.size() == 0) nu = 1;
        else void'(stk.pop_back());
      end
      m_ovf = (m_ovf && !clr) || no;
      m_unf = (m_unf && !clr) || nu;
    end
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 'h03, 0);
    step(0, 1, 0, 'h07, 0);
    step(0, 1, 0, 'h0A, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, i, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 'h01, 0);
    step(0, 1, 0, 'h02, 0);
    step(0, 1, 1, 'h1F, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 'h11, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 'h0A, 0);
    step(0, 1, 0, 'h0B, 0);
    step(1, 1, 0, 'h0C, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           int'($urandom_range(0, 31)), $urandom_range(0, 15) == 0);
    @(posedge clk);
    #1;
    rst = 0;
    push = 0;
    pop = 0;
    err_clr = 0;
    repeat (3) @(negedge clk);
    #1;
    cmp("scoreboard_drained", sb.size(), 0);
    done = 1;
  end
  initial begin
    wait (done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: done=%0d expected 1", done);
    $fatal(1, "timeout");
  end
endmodule
